// File: rtl/conv_pkg.sv
// Shared constants and elaboration-time helpers for the 3x3 convolution datapath.
// Latency: none (package only).
// Backpressure: none (package only).
package conv_pkg;

    // Taps in one 3x3 window.
    localparam int TAPS = 9;

    // Ceiling log2; 0 for n <= 1.
    function automatic int clog2_f(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

    // Operand count after `lvl` levels of pairwise reduction (odd leftovers carried).
    function automatic int node_cnt(input int n, input int lvl);
        int r;
        r = n;
        for (int i = 0; i < lvl; i++) r = (r + 1) / 2;
        return r;
    endfunction

    // Signed product width for one pixel x weight multiply.
    function automatic int prod_w(input int dw, input int ww);
        return dw + ww;
    endfunction

    // Width of one full window sum over in_ch channels.
    function automatic int sum_w(input int dw, input int ww, input int in_ch);
        return dw + ww + clog2_f(TAPS * in_ch);
    endfunction

endpackage

// File: rtl/conv_adder_tree.sv
// Pipelined signed adder tree: N operands reduced pairwise, one register level per tree level.
// Latency: clog2(N) cycles from dat_i/vld_i/tag_i to sum_o/vld_o/tag_o (0 when N == 1).
// Backpressure: none; accepts one operand set per cycle, vld/tag travel alongside the data.
// Ports: clk_i/rst_n_i clock and async active-low reset; vld_i/tag_i side-band in;
//        dat_i N packed signed IW-bit operands; vld_o/tag_o side-band out; sum_o signed OW-bit sum.
module conv_adder_tree
    import conv_pkg::*;
#(
    parameter  int N  = 72,
    parameter  int IW = 16,
    parameter  int TW = 1,
    localparam int L  = clog2_f(N),
    localparam int OW = IW + L
) (
    input  logic                 clk_i,
    input  logic                 rst_n_i,
    input  logic                 vld_i,
    input  logic [TW-1:0]        tag_i,
    input  logic [N*IW-1:0]      dat_i,
    output logic                 vld_o,
    output logic [TW-1:0]        tag_o,
    output logic signed [OW-1:0] sum_o
);

    // Every level is carried at the final width; level l values never need more
    // than IW+l bits, so the upper bits are plain sign copies until the last level.
    for (genvar l = 0; l <= L; l++) begin : g_lvl
        localparam int NN = node_cnt(N, l);
        logic signed [OW-1:0] lvl_dat [NN];
        logic                 lvl_vld;
        logic [TW-1:0]        lvl_tag;

        if (l == 0) begin : g_leaf
            for (genvar i = 0; i < N; i++) begin : g_ext
                assign lvl_dat[i] = OW'($signed(dat_i[i*IW +: IW]));
            end
            assign lvl_vld = vld_i;
            assign lvl_tag = tag_i;
        end else begin : g_node
            localparam int PN = node_cnt(N, l - 1);
            // Previous level padded to an even count; an odd leftover pairs with
            // zero, which registers it through unchanged.
            logic signed [OW-1:0] pad [2*NN];
            for (genvar j = 0; j < 2 * NN; j++) begin : g_pad
                if (j < PN) begin : g_src
                    assign pad[j] = g_lvl[l-1].lvl_dat[j];
                end else begin : g_zero
                    assign pad[j] = '0;
                end
            end

            always_ff @(posedge clk_i or negedge rst_n_i) begin
                if (!rst_n_i) begin
                    lvl_vld <= 1'b0;
                    lvl_tag <= '0;
                    for (int i = 0; i < NN; i++) lvl_dat[i] <= '0;
                end else begin
                    lvl_vld <= g_lvl[l-1].lvl_vld;
                    lvl_tag <= g_lvl[l-1].lvl_tag;
                    for (int i = 0; i < NN; i++) lvl_dat[i] <= pad[2*i] + pad[2*i+1];
                end
            end
        end
    end

    assign vld_o = g_lvl[L].lvl_vld;
    assign tag_o = g_lvl[L].lvl_tag;
    assign sum_o = g_lvl[L].lvl_dat[0];

endmodule

// File: rtl/conv_kernel_nch_acc.sv
// 3x3 convolution, IN_CH in x OUT_CH out, with bias, multi-pass accumulation, rounding shift, ReLU, saturation.
// Latency: clog2(9*IN_CH)+3 cycles from an in_valid&in_last sample to out_valid (10 at defaults).
// Backpressure: none; one pass per cycle when in_valid=1, idle cycles allowed.
// Ports: sclk/s_rst_n clock and async active-low reset; in_valid/in_first/in_last pass strobe and tags;
//        data_in window, weight_in per-output weights, bias_in per-output bias (taken with in_first);
//        bias_en/relu_en/shift layer config; out_valid result strobe; conv_out results; sat_flag per-channel clip.
module conv_kernel_nch_acc
    import conv_pkg::*;
#(
    parameter int IN_CH  = 8,
    parameter int OUT_CH = 2,
    parameter int DW     = 8,
    parameter int WW     = 8,
    parameter int BIAS_W = 32,
    parameter int ACC_W  = 32,
    parameter int OUT_W  = 24
) (
    input  logic                           sclk,
    input  logic                           s_rst_n,
    input  logic                           in_valid,
    input  logic                           in_first,
    input  logic                           in_last,
    input  logic [IN_CH*TAPS*DW-1:0]        data_in,
    input  logic [OUT_CH*IN_CH*TAPS*WW-1:0] weight_in,
    input  logic [OUT_CH*BIAS_W-1:0]        bias_in,
    input  logic                           bias_en,
    input  logic                           relu_en,
    input  logic [4:0]                     shift,
    output logic                           out_valid,
    output logic [OUT_CH*OUT_W-1:0]         conv_out,
    output logic [OUT_CH-1:0]               sat_flag
);

    localparam int NTAP   = IN_CH * TAPS;
    localparam int PROD_W = prod_w(DW, WW);
    localparam int SUM_W  = sum_w(DW, WW, IN_CH);
    // Tree side-band: {first, last, bias}; bias rides with its pass so it lines up at the acc stage.
    localparam int TW     = 2 + BIAS_W;
    localparam logic signed [ACC_W:0] RND_ONE = 1;

    logic out_valid_q;

    for (genvar o = 0; o < OUT_CH; o++) begin : g_ch
        // ---- S0: multiply ----
        logic [NTAP*PROD_W-1:0] prod_d, prod_q;
        logic                   s0_vld_q;
        logic [TW-1:0]          s0_tag_q;

        for (genvar k = 0; k < NTAP; k++) begin : g_mul
            logic signed [PROD_W-1:0] op_a, op_b;
            assign op_a = PROD_W'($signed(data_in[k*DW +: DW]));
            assign op_b = PROD_W'($signed(weight_in[(o*NTAP+k)*WW +: WW]));
            assign prod_d[k*PROD_W +: PROD_W] = op_a * op_b;
        end

        always_ff @(posedge sclk or negedge s_rst_n) begin
            if (!s_rst_n) begin
                prod_q   <= '0;
                s0_vld_q <= 1'b0;
                s0_tag_q <= '0;
            end else begin
                prod_q   <= prod_d;
                s0_vld_q <= in_valid;
                s0_tag_q <= {in_first, in_last, bias_in[o*BIAS_W +: BIAS_W]};
            end
        end

        // ---- S1..ST: reduction ----
        logic                    tree_vld;
        logic [TW-1:0]           tree_tag;
        logic signed [SUM_W-1:0] tree_sum;

        conv_adder_tree #(
            .N  (NTAP),
            .IW (PROD_W),
            .TW (TW)
        ) u_tree (
            .clk_i   (sclk),
            .rst_n_i (s_rst_n),
            .vld_i   (s0_vld_q),
            .tag_i   (s0_tag_q),
            .dat_i   (prod_q),
            .vld_o   (tree_vld),
            .tag_o   (tree_tag),
            .sum_o   (tree_sum)
        );

        // ---- Accumulate: a first pass restarts from the bias, so a new pixel
        // directly behind a finishing one never mixes with it ----
        logic signed [ACC_W-1:0] acc_d, acc_q, bias_ext, sum_ext;
        logic                    fire_q;

        always_comb begin
            bias_ext = bias_en ? ACC_W'($signed(tree_tag[BIAS_W-1:0])) : '0;
            sum_ext  = ACC_W'(tree_sum);
            acc_d    = tree_tag[TW-1] ? (bias_ext + sum_ext) : (acc_q + sum_ext);
        end

        always_ff @(posedge sclk or negedge s_rst_n) begin
            if (!s_rst_n) begin
                acc_q  <= '0;
                fire_q <= 1'b0;
            end else begin
                if (tree_vld) acc_q <= acc_d;
                fire_q <= tree_vld & tree_tag[TW-2];
            end
        end

        // ---- Post: round, ReLU, saturate. One spare bit keeps the rounding add from wrapping ----
        logic signed [ACC_W:0]   rnd, rsum, res;
        logic [OUT_W-1:0]        post_d, conv_q;
        logic                    sat_d, sat_q;

        always_comb begin
            rnd  = (shift == 5'd0) ? '0 : (RND_ONE << (shift - 5'd1));
            rsum = {acc_q[ACC_W-1], acc_q} + rnd;
            res  = rsum >>> shift;
            if (relu_en && res[ACC_W]) res = '0;
            // Fits when every bit above the output sign bit matches the sign.
            if (res[ACC_W:OUT_W-1] == {(ACC_W-OUT_W+2){res[ACC_W]}}) begin
                post_d = res[OUT_W-1:0];
                sat_d  = 1'b0;
            end else begin
                post_d = res[ACC_W] ? {1'b1, {(OUT_W-1){1'b0}}} : {1'b0, {(OUT_W-1){1'b1}}};
                sat_d  = 1'b1;
            end
        end

        always_ff @(posedge sclk or negedge s_rst_n) begin
            if (!s_rst_n) begin
                conv_q <= '0;
                sat_q  <= 1'b0;
            end else if (fire_q) begin
                conv_q <= post_d;
                sat_q  <= sat_d;
            end
        end

        assign conv_out[o*OUT_W +: OUT_W] = conv_q;
        assign sat_flag[o]                = sat_q;
    end

    // All channels share timing, so channel 0's last-pass strobe drives the output strobe.
    always_ff @(posedge sclk or negedge s_rst_n) begin
        if (!s_rst_n) out_valid_q <= 1'b0;
        else          out_valid_q <= g_ch[0].fire_q;
    end

    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_conv_kernel_nch_acc.sv
module tb_conv_kernel_nch_acc;
    localparam int IN_CH = 8, OUT_CH = 2, DW = 8, WW = 8, BIAS_W = 32, ACC_W = 32, OUT_W = 24;
    localparam int NTAP = IN_CH * 9;
    localparam int LAT  = 10;
    localparam longint SMAX = 8388607;
    localparam longint SMIN = -8388608;

    logic                            sclk = 1'b0;
    logic                            s_rst_n;
    logic                            in_valid, in_first, in_last;
    logic [NTAP*DW-1:0]              data_in;
    logic [OUT_CH*NTAP*WW-1:0]       weight_in;
    logic [OUT_CH*BIAS_W-1:0]        bias_in;
    logic                            bias_en, relu_en;
    logic [4:0]                      shift;
    logic                            out_valid;
    logic [OUT_CH*OUT_W-1:0]         conv_out;
    logic [OUT_CH-1:0]               sat_flag;

    conv_kernel_nch_acc #(
        .IN_CH(IN_CH), .OUT_CH(OUT_CH), .DW(DW), .WW(WW),
        .BIAS_W(BIAS_W), .ACC_W(ACC_W), .OUT_W(OUT_W)
    ) dut (
        .sclk(sclk), .s_rst_n(s_rst_n), .in_valid(in_valid), .in_first(in_first),
        .in_last(in_last), .data_in(data_in), .weight_in(weight_in), .bias_in(bias_in),
        .bias_en(bias_en), .relu_en(relu_en), .shift(shift), .out_valid(out_valid),
        .conv_out(conv_out), .sat_flag(sat_flag)
    );

    always #5 sclk = ~sclk;

    int cyc = 0;
    always @(posedge sclk) cyc++;

    int nchk = 0, nerr = 0, nvalid = 0;

    // Stimulus state and behavioural model
    int dat [NTAP];
    int wt  [OUT_CH][NTAP];
    int bias [OUT_CH];
    int m_acc [OUT_CH];

    typedef struct packed {
        logic [31:0]       due;
        logic [1:0][31:0]  val;
        logic [1:0]        sat;
    } exp_t;

    exp_t q [$];
    exp_t held;
    exp_t cur;

    task automatic chk(input string nm, input longint act, input longint exp);
        nchk++;
        if (act != exp) begin
            nerr++;
            $display("FAIL %s @cyc %0d: got %0d, want %0d", nm, cyc, act, exp);
        end
    endtask

    function automatic int ch_val(input int o);
        logic [OUT_W-1:0] s;
        s = conv_out[o*OUT_W +: OUT_W];
        return int'($signed(s));
    endfunction

    // Window sum, bias/accumulate, then rounding/ReLU/saturation from plain integers.
    task automatic model_pass(input bit first, input bit last);
        exp_t e;
        longint r;
        int s;
        e = '0;
        for (int o = 0; o < OUT_CH; o++) begin
            s = 0;
            for (int k = 0; k < NTAP; k++) s += dat[k] * wt[o][k];
            if (first) m_acc[o] = (bias_en ? bias[o] : 0) + s;
            else       m_acc[o] = m_acc[o] + s;
            if (last) begin
                r = longint'(m_acc[o]);
                if (shift != 0) r = r + (longint'(1) << (shift - 1));
                r = r >>> shift;
                if (relu_en && r < 0) r = 0;
                if (r > SMAX)      begin e.val[o] = 32'(SMAX); e.sat[o] = 1'b1; end
                else if (r < SMIN) begin e.val[o] = 32'(SMIN); e.sat[o] = 1'b1; end
                else               begin e.val[o] = 32'(r);    e.sat[o] = 1'b0; end
            end
        end
        if (last) begin
            e.due = 32'(cyc + LAT);
            q.push_back(e);
        end
    endtask

    task automatic pass(input bit first, input bit last);
        @(posedge sclk); #1;
        in_valid = 1'b1;
        in_first = first;
        in_last  = last;
        for (int k = 0; k < NTAP; k++) data_in[k*DW +: DW] = dat[k][7:0];
        for (int o = 0; o < OUT_CH; o++) begin
            for (int k = 0; k < NTAP; k++) weight_in[(o*NTAP+k)*WW +: WW] = wt[o][k][7:0];
            bias_in[o*BIAS_W +: BIAS_W] = bias[o];
        end
        model_pass(first, last);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge sclk); #1;
            in_valid = 1'b0;
        end
    endtask

    task automatic set_all(input int dv, input int w0, input int w1, input int b0, input int b1);
        for (int k = 0; k < NTAP; k++) begin
            dat[k]   = dv;
            wt[0][k] = w0;
            wt[1][k] = w1;
        end
        bias[0] = b0;
        bias[1] = b1;
    endtask

    task automatic randomise_pass();
        for (int k = 0; k < NTAP; k++) begin
            dat[k] = int'($urandom_range(0, 255)) - 128;
            for (int o = 0; o < OUT_CH; o++) wt[o][k] = int'($urandom_range(0, 255)) - 128;
        end
        for (int o = 0; o < OUT_CH; o++) bias[o] = int'($urandom_range(0, 200000)) - 100000;
    endtask

    task automatic wait_out(input int budget, output int at);
        at = -1;
        for (int i = 0; i < budget; i++) begin
            @(negedge sclk);
            if (out_valid === 1'b1) begin
                at = cyc;
                break;
            end
        end
        if (at < 0) begin
            nchk++;
            nerr++;
            $display("FAIL wait_out: no out_valid within %0d cycles", budget);
        end
    endtask

    // Per-cycle comparison against the model: strobe timing every cycle, values on
    // the strobe, and held values in between.
    always @(negedge sclk) begin
        while (q.size() > 0 && int'(q[0].due) < cyc) begin
            nchk++;
            nerr++;
            $display("FAIL stale_expect: result due at %0d not consumed", q[0].due);
            void'(q.pop_front());
        end
        if (out_valid === 1'b1) nvalid++;
        if (q.size() > 0 && int'(q[0].due) == cyc) begin
            chk("out_valid", longint'(out_valid), 1);
            cur  = q.pop_front();
            held = cur;
        end else begin
            chk("out_valid", longint'(out_valid), 0);
        end
        for (int o = 0; o < OUT_CH; o++) begin
            chk("conv_out", ch_val(o), longint'($signed(held.val[o])));
            chk("sat_flag", longint'(sat_flag[o]), longint'(held.sat[o]));
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int at, t0, n0;
        held = '0;
        s_rst_n = 1'b0;
        in_valid = 1'b0; in_first = 1'b0; in_last = 1'b0;
        data_in = '0; weight_in = '0; bias_in = '0;
        bias_en = 1'b1; relu_en = 1'b0; shift = 5'd0;
        for (int o = 0; o < OUT_CH; o++) m_acc[o] = 0;

        // Reset state
        repeat (2) @(negedge sclk);
        chk("rst_out_valid", longint'(out_valid), 0);
        chk("rst_conv_out", longint'(conv_out), 0);
        chk("rst_sat_flag", longint'(sat_flag), 0);
        @(posedge sclk); #1;
        s_rst_n = 1'b1;
        idle(2);

        // Single pass: 72*1 + 5 = 77, 10 cycles after the sample
        set_all(1, 1, 1, 5, 5);
        pass(1'b1, 1'b1);
        t0 = cyc;
        idle(1);
        wait_out(20, at);
        chk("single_latency", at - t0, LAT);
        chk("single_ch0", ch_val(0), 77);
        chk("single_ch1", ch_val(1), 77);
        idle(4);

        // Three passes of -144 each, one strobe only
        set_all(2, -1, -1, 0, 0);
        n0 = nvalid;
        pass(1'b1, 1'b0);
        pass(1'b0, 1'b0);
        pass(1'b0, 1'b1);
        idle(16);
        chk("three_strobes", nvalid - n0, 1);
        chk("three_ch0", ch_val(0), -432);
        chk("three_ch1", ch_val(1), -432);

        // Rounding: acc -3 -> -1, acc 3 -> 2 at shift 1
        shift = 5'd1;
        set_all(0, 1, 1, -3, 3);
        pass(1'b1, 1'b1);
        idle(1);
        wait_out(20, at);
        chk("round_neg", ch_val(0), -1);
        chk("round_pos", ch_val(1), 2);
        idle(4);
        relu_en = 1'b1;
        pass(1'b1, 1'b1);
        idle(1);
        wait_out(20, at);
        chk("relu_neg", ch_val(0), 0);
        chk("relu_pos", ch_val(1), 2);
        idle(4);

        // Saturation in both directions
        relu_en = 1'b0;
        shift = 5'd0;
        set_all(127, 127, -128, 8388608, -8388608);
        pass(1'b1, 1'b1);
        idle(1);
        wait_out(20, at);
        chk("sat_hi_val", ch_val(0), 8388607);
        chk("sat_lo_val", ch_val(1), -8388608);
        chk("sat_flags", longint'(sat_flag), 3);
        idle(4);

        // Streaming: 20 back-to-back single-pass pixels
        shift = 5'd3;
        n0 = nvalid;
        for (int i = 0; i < 20; i++) begin
            randomise_pass();
            pass(1'b1, 1'b1);
        end
        idle(16);
        chk("stream_strobes", nvalid - n0, 20);

        // Streaming 3-pass pixels, ReLU on, bias disabled
        shift = 5'd2;
        relu_en = 1'b1;
        bias_en = 1'b0;
        n0 = nvalid;
        for (int i = 0; i < 12; i++) begin
            randomise_pass();
            pass(i % 3 == 0, i % 3 == 2);
        end
        idle(16);
        chk("multi_strobes", nvalid - n0, 4);

        // Reset mid-stream: in-flight passes vanish, accumulator restarts at 0
        shift = 5'd0;
        relu_en = 1'b0;
        bias_en = 1'b1;
        for (int i = 0; i < 5; i++) begin
            randomise_pass();
            pass(1'b1, 1'b1);
        end
        @(posedge sclk); #1;
        in_valid = 1'b0;
        s_rst_n = 1'b0;
        q.delete();
        held = '0;
        for (int o = 0; o < OUT_CH; o++) m_acc[o] = 0;
        @(negedge sclk);
        chk("midrst_out_valid", longint'(out_valid), 0);
        chk("midrst_conv_out", longint'(conv_out), 0);
        @(posedge sclk); #1;
        s_rst_n = 1'b1;
        n0 = nvalid;
        idle(14);
        chk("midrst_no_strobe", nvalid - n0, 0);
        set_all(1, 1, 1, 50, 50);
        pass(1'b0, 1'b1);
        idle(1);
        wait_out(20, at);
        chk("post_rst_ch0", ch_val(0), 72);
        chk("post_rst_ch1", ch_val(1), 72);
        idle(4);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
